mod3_serial_sched: RTL and testbench

Scheduler and sequencer for a shared bit-serial divide-by-3 engine. It arbitrates round-robin between two requesters, each offering an 8-bit word over a valid/ready handshake. It feeds the granted word MSB-first through an internal 3-state remainder FSM, one bit per clock. It returns quotient, remainder and a divisible flag, tagged with the source, over a valid/ready result port. It sits between producer logic and any consumer that needs mod-3 / div-3 results without a combinational 8-stage chain.

---
 rtl/mod3_serial_sched_if.sv | 24 ++
 rtl/mod3_serial_sched.sv | 77 +++++++
 tb/tb_mod3_serial_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mod3_serial_sched_if.sv
// mod3_serial_sched_if: request, result and status signals of the divide-by-3 scheduler
interface mod3_serial_sched_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       res_valid;
  logic       res_ready;
  logic       res_src;
  logic [7:0] res_quot;
  logic [1:0] res_rem;
  logic       res_div3;
  logic       busy;
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_src, res_quot, res_rem, res_div3, busy
  );
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_src, res_quot, res_rem, res_div3, busy
  );
endinterface

// File: rtl/mod3_serial_sched.sv
// mod3_serial_sched: round-robin scheduler feeding a bit-serial divide-by-3 engine
module mod3_serial_sched (
  input logic clk,
  input logic rst,
  mod3_serial_sched_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0] state;
  logic [1:0] r;
  logic [1:0] r_eff;
  logic [1:0] r_next;
  logic [7:0] sh;
  logic [7:0] quot;
  logic [2:0] cnt;
  logic [2:0] t;
  logic       last;
  logic       src;
  logic       div3;
  logic       g0;
  logic       g1;
  logic       b;
  logic       q;
  // grant picks the lone requester, or the one not served last on a tie; one remainder step
  always_comb begin
    g0 = bus.req0_valid && (!bus.req1_valid || last);
    g1 = bus.req1_valid && (!bus.req0_valid || !last);
    r_eff = (r == 2'd3) ? 2'd0 : r;
    b = sh[cnt];
    t = {r_eff, b};
    q = t >= 3'd3;
    r_next = q ? 2'(t - 3'd3) : t[1:0];
  end
  assign bus.req0_ready = !rst && state == IDLE && g0;
  assign bus.req1_ready = !rst && state == IDLE && g1;
  assign bus.res_valid  = state == DONE;
  assign bus.busy       = state != IDLE;
  assign bus.res_src    = src;
  assign bus.res_quot   = quot;
  assign bus.res_rem    = r;
  assign bus.res_div3   = div3;
  // control FSM: accept a word, shift it MSB-first through the remainder FSM, hold the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      src   <= 1'b0;
      sh    <= '0;
      quot  <= '0;
      r     <= 2'd0;
      div3  <= 1'b0;
      cnt   <= 3'd0;
    end else if (state == IDLE) begin
      if (g0 || g1) begin
        sh    <= g1 ? bus.req1_data : bus.req0_data;
        src   <= g1;
        last  <= g1;
        r     <= 2'd0;
        quot  <= '0;
        div3  <= 1'b0;
        cnt   <= 3'd7;
        state <= SHIFT;
      end
    end else if (state == SHIFT) begin
      quot  <= {quot[6:0], q};
      r     <= r_next;
      div3  <= r_next == 2'd0;
      cnt   <= cnt - 3'd1;
      state <= (cnt == 3'd0) ? DONE : SHIFT;
    end else if (state == DONE) begin
      state <= bus.res_ready ? IDLE : DONE;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mod3_serial_sched.sv
// tb_mod3_serial_sched: scoreboard bench for the divide-by-3 scheduler
module tb_mod3_serial_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  int bacc = -1;
  logic prev_valid = 1'b0;
  typedef struct {
    logic       src;
    logic [7:0] quot;
    logic [1:0] rem;
    logic       div3;
  } exp_t;
  exp_t sbq[$];
  mod3_serial_sched_if bus ();
  mod3_serial_sched dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t mk(input logic s, input logic [7:0] qv, input logic [1:0] rv);
    exp_t e;
    e.src = s;
    e.quot = qv;
    e.rem = rv;
    e.div3 = rv == 2'd0;
    return e;
  endfunction
  // monitor: ready exclusivity while busy, latency, scoreboard compare on result handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        total++;
        if (bus.req0_ready || bus.req1_ready) begin
          bad++;
          $display("FAIL ready_in_busy: ready0=%0b ready1=%0b want 0 0 at cyc %0d", bus.req0_ready, bus.req1_ready, cyc);
        end
      end
      if (bus.res_valid && !prev_valid) begin
        total++;
        if (cyc != last_acc + 8) begin
          bad++;
          $display("FAIL latency: result after %0d edges, want 8", cyc - last_acc);
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: src=%0d quot=%0d rem=%0d", bus.res_src, bus.res_quot, bus.res_rem);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (bus.res_src !== e.src || bus.res_quot !== e.quot || bus.res_rem !== e.rem || bus.res_div3 !== e.div3) begin
            bad++;
            $display("FAIL result: got src=%0d quot=%0d rem=%0d div3=%0d, want src=%0d quot=%0d rem=%0d div3=%0d",
                     bus.res_src, bus.res_quot, bus.res_rem, bus.res_div3, e.src, e.quot, e.rem, e.div3);
          end
        end
      end
    end
    prev_valid = bus.res_valid;
  end
  task automatic drive(input logic p, input logic [7:0] d, output int acc);
    int n;
    @(posedge clk);
    #1;
    if (p) begin
      bus.req1_valid = 1'b1;
      bus.req1_data = d;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_data = d;
    end
    n = 0;
    acc = -1;
    while (n < 500) begin
      @(negedge clk);
      if (p ? bus.req1_ready : bus.req0_ready) break;
      n++;
    end
    if (n == 500) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: port %0d never granted, want a grant", p);
    end else begin
      acc = cyc + 1;
      last_acc = acc;
    end
    @(posedge clk);
    #1;
    if (p) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
  endtask
  task automatic send(input logic p, input logic [7:0] d, input logic [7:0] qv, input logic [1:0] rv);
    int a;
    sbq.push_back(mk(p, qv, rv));
    drive(p, d, a);
  endtask
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (n < 200 && (sbq.size() != 0 || bus.busy)) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n == 200) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d busy=%0b, want 0 0", nm, sbq.size(), bus.busy);
    end
  endtask
  task automatic chk_zero(input string nm);
    logic [15:0] v;
    v = {bus.req0_ready, bus.req1_ready, bus.res_valid, bus.res_src, bus.res_quot, bus.res_rem, bus.res_div3, bus.busy};
    total++;
    if (v !== 16'h0) begin
      bad++;
      $display("FAIL %s_outputs: got %h, want 0000", nm, v);
    end
  endtask
  task automatic tie(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3, input string nm);
    int a0, a1, b0, b1;
    sbq.push_back(mk(1'b0, w0 / 3, 2'(w0 % 3)));
    sbq.push_back(mk(1'b1, w2 / 3, 2'(w2 % 3)));
    sbq.push_back(mk(1'b0, w1 / 3, 2'(w1 % 3)));
    sbq.push_back(mk(1'b1, w3 / 3, 2'(w3 % 3)));
    fork
      begin drive(1'b0, w0, a0); drive(1'b0, w1, a1); end
      begin drive(1'b1, w2, b0); drive(1'b1, w3, b1); end
    join
    total++;
    if (b0 - a0 != 10 || a1 - b0 != 10 || b1 - a1 != 10) begin
      bad++;
      $display("FAIL %s_spacing: accepts at %0d %0d %0d %0d, want order 0,1,0,1 spaced 10", nm, a0, b0, a1, b1);
    end
  endtask
  initial begin
    int n;
    int a;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data = '0;
    bus.req1_data = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    send(1'b0, 8'hA9, 8'd56, 2'd1);
    send(1'b1, 8'hFF, 8'd85, 2'd0);
    send(1'b0, 8'h00, 8'd0, 2'd0);
    send(1'b1, 8'hAA, 8'd56, 2'd2);
    send(1'b0, 8'h03, 8'd1, 2'd0);
    for (int p = 0; p < 2; p++)
      for (int w = 0; w < 256; w++)
        send(p[0], w[7:0], 8'(w / 3), 2'(w % 3));
    tie(8'h11, 8'h22, 8'h33, 8'h44, "tie");
    wait_idle("tie");
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    sbq.push_back(mk(1'b0, 8'd14, 2'd0));
    drive(1'b0, 8'h2A, a);
    n = 0;
    while (n < 50 && !bus.res_valid) begin
      @(negedge clk);
      n++;
    end
    sbq.push_back(mk(1'b1, 8'd2, 2'd1));
    bacc = -1;
    fork
      begin int x; drive(1'b1, 8'h07, x); bacc = x; end
    join_none
    repeat (20) begin
      @(negedge clk);
      total++;
      if ({bus.res_valid, bus.res_src, bus.res_quot, bus.res_rem, bus.res_div3} !== {1'b1, 1'b0, 8'd14, 2'd0, 1'b1}) begin
        bad++;
        $display("FAIL hold: valid=%0b src=%0d quot=%0d rem=%0d div3=%0b, want 1 0 14 0 1",
                 bus.res_valid, bus.res_src, bus.res_quot, bus.res_rem, bus.res_div3);
      end
    end
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    a = cyc;
    n = 0;
    while (n < 50 && bacc < 0) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bacc != a + 2) begin
      bad++;
      $display("FAIL release_grant: accept at %0d, want %0d", bacc, a + 2);
    end
    wait_idle("hold");
    drive(1'b0, 8'hC5, a);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero("midshift_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      total++;
      if (bus.res_valid || bus.busy) begin
        bad++;
        $display("FAIL after_reset: valid=%0b busy=%0b, want 0 0", bus.res_valid, bus.busy);
      end
    end
    tie(8'h55, 8'h66, 8'h0C, 8'hFE, "post_reset_tie");
    wait_idle("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
